// File: rtl/ad9826_pkg.sv
// ad9826_pkg
// Shared definitions for the AD9826 serial-port responder: register
// addresses, frame layout constants and the frame decoder state type.
// No ports; imported by ad9826_regfile and ad9826_serial_responder.
package ad9826_pkg;

  // Register map addresses used by the configuration master
  localparam logic [2:0] ADDR_REG        = 3'd0;
  localparam logic [2:0] ADDR_MUX        = 3'd1;
  localparam logic [2:0] ADDR_RED_PGA    = 3'd2;
  localparam logic [2:0] ADDR_RED_OFFSET = 3'd5;

  // Frame layout
  localparam int FRAME_BITS     = 16;
  localparam int ADDR_MSB_IDX   = 1;
  localparam int ADDR_W         = 3;
  localparam int DATA_START_IDX = 7;
  localparam int DATA_W         = 9;
  localparam int NUM_REGS       = 8;

  typedef logic [3:0] bit_idx_t;

  // Bit indices pre-sized to the frame counter width
  localparam bit_idx_t ADDR_LAST_BIT  = bit_idx_t'(ADDR_MSB_IDX + ADDR_W - 1);
  localparam bit_idx_t HDR_LAST_BIT   = bit_idx_t'(DATA_START_IDX - 1);
  localparam bit_idx_t FRAME_LAST_BIT = bit_idx_t'(FRAME_BITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    DATA,
    HOLD
  } frame_state_t;

endpackage

// File: rtl/ad9826_regfile.sv
// ad9826_regfile
// 8 x 9-bit register file behind the serial responder.
// Ports:
//   clk, rst_n           : clock, synchronous active-low reset
//   we, wr_addr, wr_data : single write port
//   rd_addr, rd_data     : asynchronous read port for serial read-out
//   host_addr, host_data : registered host read port (1-cycle latency)
module ad9826_regfile
  import ad9826_pkg::*;
#(
  parameter logic [DATA_W-1:0] RST_CFG = 9'h000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [2:0]        wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [2:0]        rd_addr,
  output logic [DATA_W-1:0] rd_data,
  input  logic [2:0]        host_addr,
  output logic [DATA_W-1:0] host_data
);

  logic [DATA_W-1:0] regs [NUM_REGS];

  // Host read samples the pre-write contents, so a same-cycle write and
  // host read of one address returns the old value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 1; i < NUM_REGS; i++) regs[i] <= '0;
      regs[0]   <= RST_CFG;
      host_data <= '0;
    end else begin
      if (we) regs[wr_addr] <= wr_data;
      host_data <= regs[host_addr];
    end
  end

  assign rd_data = regs[rd_addr];

endmodule

// File: rtl/ad9826_serial_responder.sv
// ad9826_serial_responder
// Device end of the AD9826 3-wire serial port. Decodes 16-bit SLOAD/SDATA
// frames (R/W, 3-bit address, 3 ignored bits, 9-bit data MSB first),
// commits writes into an 8x9 register file and shifts read data back out.
// Ports:
//   clk, rst_n               : clock (= master SCLK), sync active-low reset
//   sload_i, sdata_i         : frame select (active low) and serial data in
//   sdata_o, sdata_oe        : serial read data and its drive enable
//   host_addr_i, host_data_o : registered host read port
//   wr_strobe_o, wr_addr_o, wr_data_o : commit pulse and last write
//   frame_err_o              : pulse when a frame ends short
module ad9826_serial_responder
  import ad9826_pkg::*;
#(
  parameter logic              RD_POL  = 1'b1,
  parameter logic [DATA_W-1:0] RST_CFG = 9'h000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sload_i,
  input  logic              sdata_i,
  output logic              sdata_o,
  output logic              sdata_oe,
  input  logic [2:0]        host_addr_i,
  output logic [DATA_W-1:0] host_data_o,
  output logic              wr_strobe_o,
  output logic [2:0]        wr_addr_o,
  output logic [DATA_W-1:0] wr_data_o,
  output logic              frame_err_o
);

  frame_state_t      state;
  bit_idx_t          bit_cnt;
  logic              rw;
  logic [2:0]        addr;
  logic [DATA_W-1:0] data_sh;
  logic [DATA_W-2:0] out_sh;
  logic              commit_pend;
  logic [DATA_W-1:0] rd_data;
  logic              is_read;

  assign is_read = (rw == RD_POL);

  ad9826_regfile #(
    .RST_CFG (RST_CFG)
  ) u_regfile (
    .clk       (clk),
    .rst_n     (rst_n),
    .we        (commit_pend),
    .wr_addr   (addr),
    .wr_data   (data_sh),
    .rd_addr   (addr),
    .rd_data   (rd_data),
    .host_addr (host_addr_i),
    .host_data (host_data_o)
  );

  // Frame decoder. bit_cnt holds the index of the bit the next edge samples.
  // A write is flagged on the bit-15 edge and committed one edge later, so
  // addr/data_sh stay stable through the commit (IDLE/HOLD never touch them
  // while sload_i is high, and a new frame needs one high cycle first).
  // Read data leaves MSB first: D8 is loaded on the bit-6 edge and the
  // remaining 8 bits shift out of out_sh one per DATA edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      rw          <= 1'b0;
      addr        <= '0;
      data_sh     <= '0;
      out_sh      <= '0;
      sdata_o     <= 1'b0;
      sdata_oe    <= 1'b0;
      frame_err_o <= 1'b0;
      commit_pend <= 1'b0;
      wr_strobe_o <= 1'b0;
      wr_addr_o   <= '0;
      wr_data_o   <= '0;
    end else begin
      frame_err_o <= 1'b0;
      commit_pend <= 1'b0;
      wr_strobe_o <= commit_pend;
      if (commit_pend) begin
        wr_addr_o <= addr;
        wr_data_o <= data_sh;
      end

      case (state)
        IDLE: begin
          if (!sload_i) begin
            rw      <= sdata_i;
            bit_cnt <= 4'd1;
            state   <= HDR;
          end
        end

        HDR: begin
          if (sload_i) begin
            state       <= IDLE;
            frame_err_o <= 1'b1;
            sdata_o     <= 1'b0;
            sdata_oe    <= 1'b0;
          end else begin
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt <= ADDR_LAST_BIT) addr <= {addr[1:0], sdata_i};
            if (bit_cnt == HDR_LAST_BIT) begin
              state <= DATA;
              if (is_read) begin
                out_sh   <= rd_data[DATA_W-2:0];
                sdata_o  <= rd_data[DATA_W-1];
                sdata_oe <= 1'b1;
              end
            end
          end
        end

        DATA: begin
          if (sload_i) begin
            state       <= IDLE;
            frame_err_o <= 1'b1;
            sdata_o     <= 1'b0;
            sdata_oe    <= 1'b0;
          end else begin
            bit_cnt <= bit_cnt + 4'd1;
            data_sh <= {data_sh[DATA_W-2:0], sdata_i};
            if (bit_cnt == FRAME_LAST_BIT) begin
              state    <= HOLD;
              sdata_o  <= 1'b0;
              sdata_oe <= 1'b0;
              if (!is_read) commit_pend <= 1'b1;
            end else if (is_read) begin
              sdata_o <= out_sh[DATA_W-2];
              out_sh  <= {out_sh[DATA_W-3:0], 1'b0};
            end
          end
        end

        HOLD: begin
          if (sload_i) state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
